// File: rtl/funct_generator_pkg.sv
// rtl/funct_generator_pkg.sv - shared state encoding and constants for the funct_generator scheduler
package funct_generator_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONF = 2'd1,
        S_RUN  = 2'd2,
        S_HOLD = 2'd3
    } sched_state_e;

    localparam logic [1:0] SEL_SIN = 2'd0;
    localparam logic [1:0] SEL_COS = 2'd1;
    localparam logic [1:0] SEL_TRI = 2'd2;
    localparam logic [1:0] SEL_SQU = 2'd3;

    // Amplitude the generator powers up with (1.0 in integer units)
    localparam int AMP_RESET = 1;

endpackage

// File: rtl/funct_generator_tick_div.sv
// rtl/funct_generator_tick_div.sv - loadable, freezable sample-period down-counter with tick output
module funct_generator_tick_div
    import funct_generator_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [DIV_WIDTH-1:0] i_load_val,
    input  logic                 i_en,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_cnt;

    // Load wins over counting; the count parks at zero until reloaded, so a due tick stays due
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/funct_generator_sched.sv
// rtl/funct_generator_sched.sv - configuration sequencer and sample pacer for funct_generator
module funct_generator_sched
    import funct_generator_pkg::*;
#(
    parameter int INT_BITS  = 4,
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [INT_BITS-1:0]  cfg_amp_i,
    input  logic [1:0]           cfg_sel_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [CNT_WIDTH-1:0] burst_len_i,
    input  logic                 fifo_full_i,
    output logic                 gen_en_n_o,
    output logic                 gen_conf_o,
    output logic [INT_BITS-1:0]  gen_amp_o,
    output logic [1:0]           gen_sel_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 cfg_err_o,
    output logic [CNT_WIDTH-1:0] sample_cnt_o
);

    // Most negative amplitude has no positive counterpart in the generator, so it is rejected
    localparam logic [INT_BITS-1:0] AMP_MIN = {1'b1, {(INT_BITS-1){1'b0}}};

    sched_state_e         r_state;
    sched_state_e         w_state_nxt;
    logic [DIV_WIDTH-1:0] r_div_m1;
    logic [DIV_WIDTH-1:0] w_div_m1_in;
    logic [DIV_WIDTH-1:0] w_load_val;
    logic [CNT_WIDTH-1:0] r_burst_len;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic [CNT_WIDTH-1:0] w_burst_eff;
    logic                 r_done_pend;
    logic                 w_tick_due;
    logic                 w_issue;
    logic                 w_start;
    logic                 w_cfg_ok;
    logic                 w_cfg_bad;
    logic                 w_burst_end;
    logic                 w_amp_bad;

    // A period of 0 behaves as 1; the divider holds period-1 so a count of 0 means "tick now"
    assign w_div_m1_in = (div_i == '0) ? '0 : (div_i - DIV_WIDTH'(1));
    assign w_load_val  = (r_state == S_IDLE) ? w_div_m1_in : r_div_m1;

    // In IDLE only a start can issue, which restarts the count and uses the live burst length
    assign w_cnt_inc   = ((r_state == S_IDLE) ? '0 : sample_cnt_o) + CNT_WIDTH'(1);
    assign w_burst_eff = (r_state == S_IDLE) ? burst_len_i : r_burst_len;

    assign w_amp_bad   = (cfg_amp_i == '0) || (cfg_amp_i == AMP_MIN);
    assign cfg_ready_o = (r_state == S_IDLE);

    funct_generator_tick_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_div (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_issue),
        .i_load_val (w_load_val),
        .i_en       (r_state == S_RUN),
        .o_tick     (w_tick_due)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle actions; config beats start, stop beats a due tick
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_start     = 1'b0;
        w_cfg_ok    = 1'b0;
        w_cfg_bad   = 1'b0;
        w_burst_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid_i) begin
                    if (w_amp_bad) begin
                        w_cfg_bad = 1'b1;
                    end else begin
                        w_cfg_ok    = 1'b1;
                        w_state_nxt = S_CONF;
                    end
                end else if (start_i) begin
                    w_start     = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_CONF: begin
                w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                if (stop_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick_due) begin
                    if (fifo_full_i) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_issue = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (stop_i) begin
                    w_state_nxt = S_IDLE;
                end else if (!fifo_full_i) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_issue && (w_burst_eff != '0) && (w_cnt_inc == w_burst_eff)) begin
            w_burst_end = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    // Registered outputs and run parameters latched at start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_en_n_o   <= 1'b1;
            gen_conf_o   <= 1'b0;
            gen_amp_o    <= INT_BITS'(AMP_RESET);
            gen_sel_o    <= SEL_SIN;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            cfg_err_o    <= 1'b0;
            sample_cnt_o <= '0;
            r_done_pend  <= 1'b0;
            r_div_m1     <= '0;
            r_burst_len  <= '0;
        end else begin
            gen_en_n_o  <= ~w_issue;
            gen_conf_o  <= w_cfg_ok;
            cfg_err_o   <= w_cfg_bad;
            busy_o      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
            r_done_pend <= w_burst_end;
            done_o      <= r_done_pend;
            if (w_cfg_ok) begin
                gen_amp_o <= cfg_amp_i;
                gen_sel_o <= cfg_sel_i;
            end
            if (w_start) begin
                r_div_m1    <= w_div_m1_in;
                r_burst_len <= burst_len_i;
            end
            if (w_issue) begin
                sample_cnt_o <= w_cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_funct_generator_sched.sv
// tb/tb_funct_generator_sched.sv - self-checking bench for funct_generator_sched
module tb_funct_generator_sched;

    localparam int INT_BITS  = 4;
    localparam int DIV_WIDTH = 16;
    localparam int CNT_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start_i;
    logic                 stop_i;
    logic                 cfg_valid_i;
    logic                 cfg_ready_o;
    logic [INT_BITS-1:0]  cfg_amp_i;
    logic [1:0]           cfg_sel_i;
    logic [DIV_WIDTH-1:0] div_i;
    logic [CNT_WIDTH-1:0] burst_len_i;
    logic                 fifo_full_i;
    logic                 gen_en_n_o;
    logic                 gen_conf_o;
    logic [INT_BITS-1:0]  gen_amp_o;
    logic [1:0]           gen_sel_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 cfg_err_o;
    logic [CNT_WIDTH-1:0] sample_cnt_o;

    always #5 clk = ~clk;

    funct_generator_sched #(
        .INT_BITS  (INT_BITS),
        .DIV_WIDTH (DIV_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_amp_i    (cfg_amp_i),
        .cfg_sel_i    (cfg_sel_i),
        .div_i        (div_i),
        .burst_len_i  (burst_len_i),
        .fifo_full_i  (fifo_full_i),
        .gen_en_n_o   (gen_en_n_o),
        .gen_conf_o   (gen_conf_o),
        .gen_amp_o    (gen_amp_o),
        .gen_sel_o    (gen_sel_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cfg_err_o    (cfg_err_o),
        .sample_cnt_o (sample_cnt_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: absolute due times instead of a down-counter; a full FIFO just defers
    int          cyc;
    bit          m_running;
    bit          m_conf;
    bit          m_done_pend;
    int          m_due;
    int          m_div;
    logic [15:0] m_count;
    logic [15:0] m_burst;
    logic [3:0]  m_amp;
    logic [1:0]  m_sel;
    logic        e_en_n;
    logic        e_conf;
    logic        e_err;
    logic        e_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_running   = 0;
        m_conf      = 0;
        m_done_pend = 0;
        m_due       = 0;
        m_div       = 1;
        m_count     = 0;
        m_burst     = 0;
        m_amp       = 4'd1;
        m_sel       = 2'd0;
        e_en_n      = 1;
        e_conf      = 0;
        e_err       = 0;
        e_done      = 0;
    endtask

    task automatic model_issue();
        e_en_n    = 0;
        m_count   = m_count + 16'd1;
        m_due     = cyc + m_div;
        m_running = 1;
        if (m_burst != 0 && m_count == m_burst) begin
            m_running   = 0;
            m_done_pend = 1;
        end
    endtask

    task automatic model_step();
        e_en_n      = 1;
        e_conf      = 0;
        e_err       = 0;
        e_done      = m_done_pend;
        m_done_pend = 0;
        if (m_conf) begin
            m_conf = 0;
        end else if (!m_running) begin
            if (cfg_valid_i) begin
                if (cfg_amp_i == 4'd0 || cfg_amp_i == 4'd8) begin
                    e_err = 1;
                end else begin
                    m_amp  = cfg_amp_i;
                    m_sel  = cfg_sel_i;
                    e_conf = 1;
                    m_conf = 1;
                end
            end else if (start_i) begin
                m_div   = (div_i == 0) ? 1 : int'(div_i);
                m_burst = burst_len_i;
                m_count = 0;
                model_issue();
            end
        end else begin
            if (stop_i) begin
                m_running = 0;
            end else if (cyc >= m_due && !fifo_full_i) begin
                model_issue();
            end
        end
    endtask

    task automatic compare_all();
        check($sformatf("gen_en_n@%0d", cyc), gen_en_n_o, e_en_n);
        check($sformatf("gen_conf@%0d", cyc), gen_conf_o, e_conf);
        check($sformatf("cfg_err@%0d", cyc), cfg_err_o, e_err);
        check($sformatf("done@%0d", cyc), done_o, e_done);
        check($sformatf("busy@%0d", cyc), busy_o, m_running);
        check($sformatf("cfg_ready@%0d", cyc), cfg_ready_o, !m_running && !m_conf);
        check($sformatf("sample_cnt@%0d", cyc), sample_cnt_o, m_count);
        check($sformatf("gen_amp@%0d", cyc), gen_amp_o, m_amp);
        check($sformatf("gen_sel@%0d", cyc), gen_sel_o, m_sel);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        cyc++;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_en_n"}, gen_en_n_o, 1'b1);
        check({pfx, "_conf"}, gen_conf_o, 1'b0);
        check({pfx, "_amp"}, gen_amp_o, 4'd1);
        check({pfx, "_sel"}, gen_sel_o, 2'd0);
        check({pfx, "_busy"}, busy_o, 1'b0);
        check({pfx, "_done"}, done_o, 1'b0);
        check({pfx, "_err"}, cfg_err_o, 1'b0);
        check({pfx, "_cnt"}, sample_cnt_o, 16'd0);
        check({pfx, "_ready"}, cfg_ready_o, 1'b1);
    endtask

    initial begin
        int lows[$];
        int done_at;
        int stall_lows;
        int total_lows;

        rst         = 1'b0;
        start_i     = 1'b0;
        stop_i      = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_amp_i   = '0;
        cfg_sel_i   = '0;
        div_i       = 16'd1;
        burst_len_i = '0;
        fifo_full_i = 1'b0;
        cyc         = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;
        step();
        step();

        // Legal configuration
        cfg_valid_i = 1'b1; cfg_amp_i = 4'd2; cfg_sel_i = 2'd3;
        step();
        cfg_valid_i = 1'b0;
        check("cfg_conf_pulse", gen_conf_o, 1'b1);
        check("cfg_amp", gen_amp_o, 4'd2);
        check("cfg_sel", gen_sel_o, 2'd3);
        check("cfg_no_err", cfg_err_o, 1'b0);
        check("cfg_ready_in_conf", cfg_ready_o, 1'b0);
        step();
        check("cfg_conf_one_cycle", gen_conf_o, 1'b0);
        check("cfg_back_idle", cfg_ready_o, 1'b1);

        // Illegal amplitudes 0 and -8
        cfg_valid_i = 1'b1; cfg_amp_i = 4'd0; cfg_sel_i = 2'd1;
        step();
        cfg_valid_i = 1'b0;
        check("bad0_err", cfg_err_o, 1'b1);
        check("bad0_conf", gen_conf_o, 1'b0);
        check("bad0_amp_kept", gen_amp_o, 4'd2);
        step();
        cfg_valid_i = 1'b1; cfg_amp_i = 4'h8; cfg_sel_i = 2'd0;
        step();
        cfg_valid_i = 1'b0;
        check("bad8_err", cfg_err_o, 1'b1);
        check("bad8_sel_kept", gen_sel_o, 2'd3);
        step();
        check("bad8_err_one_cycle", cfg_err_o, 1'b0);

        // Start and config together: only the config is applied
        cfg_valid_i = 1'b1; cfg_amp_i = 4'd5; cfg_sel_i = 2'd1;
        start_i = 1'b1; div_i = 16'd2; burst_len_i = 16'd3;
        step();
        cfg_valid_i = 1'b0; start_i = 1'b0;
        check("both_conf", gen_conf_o, 1'b1);
        check("both_no_tick", gen_en_n_o, 1'b1);
        step();
        step();
        check("both_not_busy", busy_o, 1'b0);

        // Finite burst: period 4, five samples
        div_i = 16'd4; burst_len_i = 16'd5; start_i = 1'b1;
        step();
        start_i = 1'b0;
        done_at = -1;
        if (!gen_en_n_o) lows.push_back(1);
        for (int r = 2; r <= 22; r++) begin
            step();
            if (!gen_en_n_o) lows.push_back(r);
            if (done_o) done_at = r;
        end
        check("burst_ntick", lows.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("burst_tick%0d", i), (i < lows.size()) ? lows[i] : -1, 1 + 4 * i);
        check("burst_done_at", done_at, 18);
        check("burst_cnt", sample_cnt_o, 16'd5);
        check("burst_idle", busy_o, 1'b0);

        // FIFO stall, period 1, continuous
        div_i = 16'd1; burst_len_i = 16'd0; start_i = 1'b1;
        total_lows = 0;
        step();
        start_i = 1'b0;
        if (!gen_en_n_o) total_lows++;
        repeat (5) begin
            step();
            if (!gen_en_n_o) total_lows++;
        end
        fifo_full_i = 1'b1;
        stall_lows = 0;
        repeat (5) begin
            step();
            if (!gen_en_n_o) stall_lows++;
        end
        check("stall_no_tick", stall_lows, 0);
        check("stall_busy", busy_o, 1'b1);
        fifo_full_i = 1'b0;
        step();
        check("stall_resume", gen_en_n_o, 1'b0);
        if (!gen_en_n_o) total_lows++;
        repeat (4) begin
            step();
            if (!gen_en_n_o) total_lows++;
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        if (!gen_en_n_o) total_lows++;
        step();
        check("stall_count", sample_cnt_o, total_lows);

        // Stop arriving on the edge a tick is due
        div_i = 16'd3; burst_len_i = 16'd0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check("stop_no_tick", gen_en_n_o, 1'b1);
        check("stop_idle", busy_o, 1'b0);
        step();
        check("stop_no_done", done_o, 1'b0);
        check("stop_cnt_held", sample_cnt_o, 16'd1);

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            cfg_valid_i = ($urandom_range(15) == 0);
            cfg_amp_i   = 4'($urandom_range(15));
            cfg_sel_i   = 2'($urandom_range(3));
            start_i     = ($urandom_range(7) == 0);
            stop_i      = ($urandom_range(39) == 0);
            if ($urandom_range(5) == 0) fifo_full_i = ~fifo_full_i;
            div_i       = 16'($urandom_range(5));
            burst_len_i = 16'($urandom_range(6));
            step();
        end
        cfg_valid_i = 1'b0; start_i = 1'b0; fifo_full_i = 1'b0;
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        step();
        step();

        // Reset asserted while holding for a full FIFO
        div_i = 16'd2; burst_len_i = 16'd0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        fifo_full_i = 1'b1;
        repeat (4) step();
        check("hold_busy", busy_o, 1'b1);
        rst = 1'b0;
        #1;
        check_reset_values("midrun_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        fifo_full_i = 1'b0;
        step();
        div_i = 16'd1; burst_len_i = 16'd3; start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("rerun_first_tick", gen_en_n_o, 1'b0);
        check("rerun_cnt1", sample_cnt_o, 16'd1);
        repeat (5) step();
        check("rerun_cnt3", sample_cnt_o, 16'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/funct_generator_sched.md
# funct_generator_sched

Sample scheduler and configuration sequencer for the `funct_generator` datapath. It accepts amplitude/waveform configuration from a host over a valid/ready handshake, applies it to the generator through a one-cycle configuration strobe, and paces sample generation at a programmable period. Generation stops for a finite burst length or on command, and stalls while the downstream sample FIFO is full. It sits between the host register interface and `funct_generator`, and drives that block's enable and configuration inputs.

## Interface
- `INT_BITS`, 4: integer bits of amplitude; must match the generator.
- `DIV_WIDTH`, 16: width of the sample-period divider.
- `CNT_WIDTH`, 16: width of the burst length and the sample counter.
- `clk` in 1: single clock domain.
- `rst` in 1: reset, asynchronous, active-low.
- `start_i` in 1: one-cycle pulse; starts generation.
- `stop_i` in 1: one-cycle pulse; aborts generation.
- `cfg_valid_i` in 1: a configuration is offered.
- `cfg_ready_o` out 1: the scheduler accepts the configuration; high only in IDLE.
- `cfg_amp_i` in INT_BITS: signed integer amplitude.
- `cfg_sel_i` in 2: waveform select (0 sin, 1 cos, 2 triangular, 3 square).
- `div_i` in DIV_WIDTH: sample period in clk cycles; latched at start; 0 is treated as 1.
- `burst_len_i` in CNT_WIDTH: number of samples per run; latched at start; 0 means continuous.
- `fifo_full_i` in 1: the downstream FIFO cannot accept a sample.
- `gen_en_n_o` out 1: active-low generator step enable; low for exactly one cycle per sample.
- `gen_conf_o` out 1: one-cycle configuration strobe to the generator.
- `gen_amp_o` out INT_BITS: held amplitude to the generator.
- `gen_sel_o` out 2: held waveform select to the generator.
- `busy_o` out 1: high in RUN or HOLD.
- `done_o` out 1: one-cycle pulse when a finite burst completes.
- `cfg_err_o` out 1: one-cycle pulse when an illegal amplitude is rejected.
- `sample_cnt_o` out CNT_WIDTH: number of samples issued in the current or most recent run.

## Operation
- The FSM has four states: IDLE, CONF, RUN, HOLD.
- **IDLE:**
  - If `cfg_valid_i` is high, the configuration is accepted in the same cycle.
  - If `cfg_amp_i` is 0 or -2^(INT_BITS-1): pulse `cfg_err_o`, leave `gen_amp_o`/`gen_sel_o` unchanged, remain in IDLE.
  - Otherwise: latch amp and sel, go to CONF.
  - Else if `start_i` is high: latch `div_i` and `burst_len_i`, clear `sample_cnt_o`, go to RUN, and issue the first tick immediately.
  - If `cfg_valid_i` and `start_i` arrive together, configuration wins and `start_i` is dropped.
- **CONF:** assert `gen_conf_o` for one cycle, then return to IDLE. `cfg_ready_o` is low in this state.
- **RUN:**
  - A down-counter counts `div_q`-1 to 0. At 0 a tick is due.
  - If a tick is due and `fifo_full_i` is low: drive `gen_en_n_o` low, increment `sample_cnt_o`, reload the counter.
  - If a tick is due and `fifo_full_i` is high: go to HOLD with the tick pending. The counter is frozen.
- **HOLD:** issue the pending tick in the first cycle `fifo_full_i` is sampled low, then return to RUN with the counter reloaded. No ticks are lost or merged.
- **Burst end:** if `burst_len_q` is nonzero and the tick just issued makes the count equal `burst_len_q`, go to IDLE and pulse `done_o` in the next cycle.
- **Stop:** `stop_i` in RUN or HOLD goes to IDLE. It takes priority over a tick due in the same cycle. `done_o` is not pulsed. `sample_cnt_o` holds its value.
- **Counter width:** `sample_cnt_o` wraps modulo 2^CNT_WIDTH in continuous mode.
- **Ignored inputs:** `start_i` outside IDLE is ignored. `stop_i` in IDLE or CONF is ignored.

## Timing
- All outputs are registered except `cfg_ready_o`, which is decoded from the state.
- Reset values:
  - State IDLE; `gen_en_n_o`=1, `gen_conf_o`=0.
  - `gen_amp_o`=1 (amplitude 1.0), `gen_sel_o`=0.
  - `busy_o`=0, `done_o`=0, `cfg_err_o`=0, `sample_cnt_o`=0; `cfg_ready_o`=1.
- **Start latency:** `start_i` high in cycle N gives `gen_en_n_o` low in cycle N+1. Subsequent ticks occur every max(`div_q`,1) cycles while the FIFO is not full.
- **Config latency:** handshake in cycle N gives `gen_amp_o`/`gen_sel_o` updated and `gen_conf_o` high in cycle N+1, with IDLE again in N+2.
- **FIFO full:** `fifo_full_i` is sampled on the edge that would issue the tick. If full is sampled at cycle T, the tick is issued in the cycle after the first low sample.
- **Reset mid-run:** an asynchronous reset during RUN or HOLD drives `gen_en_n_o` high immediately and discards the pending tick.

## Structure
- Shared package `funct_generator_pkg` holds:
  - the state enum `sched_state_e`;
  - the waveform select constants `SEL_SIN`/`SEL_COS`/`SEL_TRI`/`SEL_SQU`;
  - the `AMP_RESET` constant.
- Sub-module `funct_generator_tick_div` implements the loadable, freezable down-counter with tick output and parameter `DIV_WIDTH`.

## Test plan
- **Configure:** after reset, `cfg_valid_i` with amp=2, sel=3 → `gen_conf_o` pulses 1 cycle later, `gen_amp_o`=2, `gen_sel_o`=3, `cfg_err_o`=0.
- **Illegal amplitude:** amp=0, then amp=-8 → `cfg_err_o` pulses each time, no `gen_conf_o`, outputs keep their prior values.
- **Finite burst:** `div_i`=4, `burst_len_i`=5, start at cycle 10 → `gen_en_n_o` low at cycles 11, 15, 19, 23, 27; `done_o` at 28; `sample_cnt_o`=5.
- **FIFO stall:** `div_i`=1, `fifo_full_i` high for cycles 20–24 → no ticks while full, one tick in the cycle after the first low sample, no lost samples; the total count matches the number of ticks.
- **Stop:** `stop_i` in the same cycle as a due tick → no tick, IDLE, no `done_o`. Start and cfg together → only config applied.
- **Reset mid-run:** `rst` low during HOLD → all outputs at reset values at once; a run after release starts cleanly from count 0.
